// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state codes, key codes and chain-step helper for the door-lock controller
//
// Contents:
//   ST_*         5-bit state codes. The key classifier decodes RAM address and
//                write-enable from these values, so they must not be renumbered.
//   lock_state_e enum built from the ST_* codes
//   IN_*         2-bit classifier codes presented on `in`
//   step_next()  successor of a state along the V, C and W key chains
package lock_pkg;

    localparam logic [4:0] ST_IDLE    = 5'd0;
    localparam logic [4:0] ST_V1      = 5'd1;
    localparam logic [4:0] ST_V2      = 5'd2;
    localparam logic [4:0] ST_FAIL    = 5'd3;
    localparam logic [4:0] ST_V3      = 5'd4;
    localparam logic [4:0] ST_OPEN    = 5'd5;
    localparam logic [4:0] ST_V4      = 5'd6;
    localparam logic [4:0] ST_CHK     = 5'd7;
    localparam logic [4:0] ST_C1      = 5'd8;
    localparam logic [4:0] ST_C2      = 5'd9;
    localparam logic [4:0] ST_C3      = 5'd11;
    localparam logic [4:0] ST_C4      = 5'd13;
    localparam logic [4:0] ST_CHKC    = 5'd14;
    localparam logic [4:0] ST_LOCKOUT = 5'd16;
    localparam logic [4:0] ST_W1      = 5'd17;
    localparam logic [4:0] ST_W2      = 5'd18;
    localparam logic [4:0] ST_W3      = 5'd19;
    localparam logic [4:0] ST_W4      = 5'd20;

    typedef enum logic [4:0] {
        S_IDLE    = ST_IDLE,
        S_V1      = ST_V1,
        S_V2      = ST_V2,
        S_FAIL    = ST_FAIL,
        S_V3      = ST_V3,
        S_OPEN    = ST_OPEN,
        S_V4      = ST_V4,
        S_CHK     = ST_CHK,
        S_C1      = ST_C1,
        S_C2      = ST_C2,
        S_C3      = ST_C3,
        S_C4      = ST_C4,
        S_CHKC    = ST_CHKC,
        S_LOCKOUT = ST_LOCKOUT,
        S_W1      = ST_W1,
        S_W2      = ST_W2,
        S_W3      = ST_W3,
        S_W4      = ST_W4
    } lock_state_e;

    localparam logic [1:0] IN_MATCH = 2'b00;
    localparam logic [1:0] IN_MISS  = 2'b01;
    localparam logic [1:0] IN_STAR  = 2'b10;
    localparam logic [1:0] IN_HASH  = 2'b11;

    // One key advances each four-step chain; the last step of the entry
    // chains lands on the check state, the write chain returns to IDLE.
    function automatic lock_state_e step_next(input lock_state_e s);
        case (s)
            S_V1:    step_next = S_V2;
            S_V2:    step_next = S_V3;
            S_V3:    step_next = S_V4;
            S_V4:    step_next = S_CHK;
            S_C1:    step_next = S_C2;
            S_C2:    step_next = S_C3;
            S_C3:    step_next = S_C4;
            S_C4:    step_next = S_CHKC;
            S_W1:    step_next = S_W2;
            S_W2:    step_next = S_W3;
            S_W3:    step_next = S_W4;
            default: step_next = S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with a done pulse on its final counting cycle
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears the count
//   load      reload count from load_val (has priority over en)
//   load_val  reload value, number of enabled cycles until done
//   en        decrement enable
//   done      high in the enabled cycle in which the count is 1
module lock_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = en && !load && (count == WIDTH'(1));

endmodule

// File: rtl/lock_ctrl_fsm.sv
// rtl/lock_ctrl_fsm.sv - door-lock controller: verify, password change, fail counting and lockout
//
// Optional feature macro: AUTO_RELOCK_EN (OPEN relocks after RELOCK_CYCLES idle cycles).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   key_valid   one-cycle strobe per keypress
//   in          classifier code (match / mismatch / '*' / '#')
//   st          current state code, fed back to the classifier
//   unlocked    high while in OPEN
//   fail        high while in FAIL
//   locked_out  high while in LOCKOUT
module lock_ctrl_fsm
    import lock_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
`ifdef AUTO_RELOCK_EN
    ,
    parameter int RELOCK_CYCLES  = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [1:0] in,
    output logic [4:0] st,
    output logic       unlocked,
    output logic       fail,
    output logic       locked_out
);

    localparam int         LOCK_W      = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [1:0] MAX_FAILS_2 = 2'(MAX_FAILS);

    lock_state_e state;
    lock_state_e state_nxt;
    logic        mismatch;
    logic        mismatch_nxt;
    logic [1:0]  fail_cnt;
    logic [1:0]  fail_cnt_nxt;
    logic [1:0]  fail_inc;
    logic        is_star;
    logic        is_hash;

    // Lockout timer reloads whenever we are outside LOCKOUT, so it holds
    // the full count on the first LOCKOUT cycle.
    logic lock_load;
    logic lock_en;
    logic lock_done;

    assign lock_en   = (state == S_LOCKOUT);
    assign lock_load = !lock_en;

    lock_timer #(
        .WIDTH (LOCK_W)
    ) u_lockout_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lock_load),
        .load_val (LOCK_W'(LOCKOUT_CYCLES)),
        .en       (lock_en),
        .done     (lock_done)
    );

`ifdef AUTO_RELOCK_EN
    localparam int RELOCK_W = $clog2(RELOCK_CYCLES + 1);

    // Any key while OPEN reloads the count, so only a quiet stretch relocks.
    logic relock_load;
    logic relock_en;
    logic relock_done;

    assign relock_en   = (state == S_OPEN) && !key_valid;
    assign relock_load = (state != S_OPEN) || key_valid;

    lock_timer #(
        .WIDTH (RELOCK_W)
    ) u_relock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (relock_load),
        .load_val (RELOCK_W'(RELOCK_CYCLES)),
        .en       (relock_en),
        .done     (relock_done)
    );
`endif

    assign is_star  = key_valid && (in == IN_STAR);
    assign is_hash  = key_valid && (in == IN_HASH);
    assign fail_inc = (fail_cnt >= MAX_FAILS_2) ? MAX_FAILS_2 : fail_cnt + 2'd1;

    always_comb begin
        state_nxt    = state;
        mismatch_nxt = mismatch;
        fail_cnt_nxt = fail_cnt;
        case (state)
            S_IDLE: begin
                if (is_star) begin
                    state_nxt    = S_V1;
                    mismatch_nxt = 1'b0;
                end else if (is_hash) begin
                    state_nxt    = S_C1;
                    mismatch_nxt = 1'b0;
                end
            end
            S_V1, S_V2, S_V3, S_V4, S_C1, S_C2, S_C3, S_C4: begin
                if (is_star) begin
                    state_nxt    = (state >= S_C1) ? S_C1 : S_V1;
                    mismatch_nxt = 1'b0;
                end else if (is_hash) begin
                    state_nxt = S_IDLE;
                end else if (key_valid) begin
                    if (in == IN_MISS) begin
                        mismatch_nxt = 1'b1;
                    end
                    state_nxt = step_next(state);
                end
            end
            S_CHK, S_CHKC: begin
                if (mismatch) begin
                    fail_cnt_nxt = fail_inc;
                    state_nxt    = (fail_inc == MAX_FAILS_2) ? S_LOCKOUT : S_FAIL;
                end else begin
                    fail_cnt_nxt = 2'd0;
                    state_nxt    = (state == S_CHK) ? S_OPEN : S_W1;
                end
            end
            S_FAIL: begin
                if (key_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OPEN: begin
                if (is_hash) begin
                    state_nxt = S_W1;
                end else if (is_star) begin
                    state_nxt = S_IDLE;
                end
`ifdef AUTO_RELOCK_EN
                else if (relock_done) begin
                    state_nxt = S_IDLE;
                end
`endif
            end
            // Every code, '*' and '#' included, is a password symbol here.
            S_W1, S_W2, S_W3, S_W4: begin
                if (key_valid) begin
                    state_nxt = step_next(state);
                end
            end
            S_LOCKOUT: begin
                if (lock_done) begin
                    state_nxt    = S_IDLE;
                    fail_cnt_nxt = 2'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with st.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mismatch   <= 1'b0;
            fail_cnt   <= 2'd0;
            unlocked   <= 1'b0;
            fail       <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            mismatch   <= mismatch_nxt;
            fail_cnt   <= fail_cnt_nxt;
            unlocked   <= (state_nxt == S_OPEN);
            fail       <= (state_nxt == S_FAIL);
            locked_out <= (state_nxt == S_LOCKOUT);
        end
    end

    assign st = state;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb/tb_lock_ctrl_fsm.sv - self-checking bench for lock_ctrl_fsm with a phase-level reference model
module tb_lock_ctrl_fsm;

    localparam int MF = 3;
    localparam int LC = 16;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [1:0] in;
    logic [4:0] st;
    logic       unlocked;
    logic       fail;
    logic       locked_out;

    int tests;
    int failed;

    lock_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .in         (in),
        .st         (st),
        .unlocked   (unlocked),
        .fail       (fail),
        .locked_out (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase of the dialogue plus a step counter.
    // phases: 0 idle, 1 entering digits, 2 checking, 3 fail, 4 open, 5 writing, 6 lockout
    int m_ph;
    int m_n;
    bit m_chg;
    bit m_mm;
    int m_fc;
    int m_lk;

    function automatic int exp_st();
        int vc[4] = '{1, 2, 4, 6};
        int cc[4] = '{8, 9, 11, 13};
        int wc[4] = '{17, 18, 19, 20};
        case (m_ph)
            1:       return m_chg ? cc[m_n] : vc[m_n];
            2:       return m_chg ? 14 : 7;
            3:       return 3;
            4:       return 5;
            5:       return wc[m_n];
            6:       return 16;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_n = 0; m_chg = 0; m_mm = 0; m_fc = 0; m_lk = 0;
        end else begin
            case (m_ph)
                0: if (key_valid && in >= 2) begin
                    m_ph = 1; m_n = 0; m_mm = 0; m_chg = (in == 3);
                end
                1: if (key_valid) begin
                    if (in == 2) begin
                        m_n = 0; m_mm = 0;
                    end else if (in == 3) begin
                        m_ph = 0;
                    end else begin
                        if (in == 1) m_mm = 1;
                        m_n++;
                        if (m_n == 4) m_ph = 2;
                    end
                end
                2: begin
                    if (m_mm) begin
                        m_fc = (m_fc + 1 > MF) ? MF : m_fc + 1;
                        if (m_fc == MF) begin
                            m_ph = 6; m_lk = LC;
                        end else begin
                            m_ph = 3;
                        end
                    end else begin
                        m_fc = 0;
                        m_n  = 0;
                        m_ph = m_chg ? 5 : 4;
                    end
                end
                3: if (key_valid) m_ph = 0;
                4: if (key_valid && in == 3) begin
                    m_ph = 5; m_n = 0;
                end else if (key_valid && in == 2) begin
                    m_ph = 0;
                end
                5: if (key_valid) begin
                    m_n++;
                    if (m_n == 4) m_ph = 0;
                end
                6: begin
                    m_lk--;
                    if (m_lk == 0) begin
                        m_ph = 0; m_fc = 0;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("model_st", int'(st), exp_st());
            check("model_unlocked", int'(unlocked), int'(m_ph == 4));
            check("model_fail", int'(fail), int'(m_ph == 3));
            check("model_locked_out", int'(locked_out), int'(m_ph == 6));
            check("model_fail_cnt", int'(dut.fail_cnt), m_fc);
        end
    end

    // All sequencing tasks start and end on a falling edge.
    task automatic press(input logic [1:0] c);
        key_valid = 1'b1;
        in        = c;
        @(negedge clk);
        key_valid = 1'b0;
        in        = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bad_entry();
        press(2'b10); press(2'b00); press(2'b00); press(2'b01); press(2'b00);
        check("bad_chk", int'(st), 7);
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1; key_valid = 1'b0; in = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_st", int'(st), 0);
        check("rst_outs", int'({unlocked, fail, locked_out}), 0);
        reset = 1'b0;
        idle(1);

        // Unlock
        press(2'b10);                 check("unl_v1", int'(st), 1);
        press(2'b00);                 check("unl_v2", int'(st), 2);
        press(2'b00);                 check("unl_v3", int'(st), 4);
        press(2'b00);                 check("unl_v4", int'(st), 6);
        press(2'b00);                 check("unl_chk", int'(st), 7);
        idle(1);                      check("unl_open", int'(st), 5);
        check("unl_flag", int'(unlocked), 1);
        press(2'b00);                 check("open_digit_ignored", int'(st), 5);
        press(2'b10);                 check("open_relock", int'(st), 0);

        // Bad code
        bad_entry();
        check("bad_fail_st", int'(st), 3);
        check("bad_fail_flag", int'(fail), 1);
        check("bad_fail_cnt", int'(dut.fail_cnt), 1);
        press(2'b00);                 check("fail_to_idle", int'(st), 0);

        // Abort and restart
        press(2'b10); press(2'b00);   check("abort_pre", int'(st), 2);
        press(2'b11);                 check("abort_idle", int'(st), 0);
        check("abort_cnt_kept", int'(dut.fail_cnt), 1);
        press(2'b10); press(2'b00); press(2'b01);
        check("restart_pre", int'(st), 4);
        press(2'b10);                 check("restart_v1", int'(st), 1);
        repeat (4) press(2'b00);
        idle(1);                      check("restart_open", int'(st), 5);
        check("restart_cnt_clr", int'(dut.fail_cnt), 0);

        // Change from OPEN, with '*' and '#' stored as symbols
        press(2'b11);                 check("chg_w1", int'(st), 17);
        press(2'b00);                 check("chg_w2", int'(st), 18);
        press(2'b01);                 check("chg_w3", int'(st), 19);
        press(2'b10);                 check("chg_w4", int'(st), 20);
        press(2'b11);                 check("chg_done", int'(st), 0);
        press(2'b10); repeat (4) press(2'b00);
        idle(1);                      check("chg_reopen", int'(st), 5);
        press(2'b10);                 check("chg_relock", int'(st), 0);

        // Change path from IDLE
        press(2'b11);                 check("cp_c1", int'(st), 8);
        press(2'b00);                 check("cp_c2", int'(st), 9);
        press(2'b00);                 check("cp_c3", int'(st), 11);
        press(2'b00);                 check("cp_c4", int'(st), 13);
        press(2'b00);                 check("cp_chkc", int'(st), 14);
        idle(1);                      check("cp_w1", int'(st), 17);
        repeat (4) press(2'b00);      check("cp_done", int'(st), 0);

        // Lockout after three consecutive failures
        bad_entry();                  check("lk_fail1", int'(st), 3);
        press(2'b00);
        bad_entry();                  check("lk_fail2", int'(st), 3);
        press(2'b00);
        bad_entry();                  check("lk_enter", int'(st), 16);
        check("lk_flag", int'(locked_out), 1);
        for (int i = 0; i < LC - 1; i++) begin
            press(2'((i % 4)));
            check("lk_hold", int'(st), 16);
        end
        idle(1);                      check("lk_exit", int'(st), 0);
        check("lk_cnt_clr", int'(dut.fail_cnt), 0);

        // Asynchronous reset mid-entry
        press(2'b10); press(2'b00); press(2'b00);
        check("ar_pre", int'(st), 4);
        #2 reset = 1'b1;
        #1 check("ar_st", int'(st), 0);
        check("ar_outs", int'({unlocked, fail, locked_out}), 0);
        idle(2);
        reset = 1'b0;
        idle(3);
        check("ar_after", int'(st), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
